// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : RAW hazard detector for the pipelined Beta core. Drives the
//            IF/ID stall and the ID/EX bubble from an in-flight dest scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
    parameter int PIPE_DEPTH = 3,
    parameter int BYPASS     = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             id_ra2sel,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] c_op_ld  = 6'b011000;
    localparam logic [5:0] c_op_st  = 6'b011001;
    localparam logic [5:0] c_op_jmp = 6'b011011;
    localparam logic [5:0] c_op_beq = 6'b011100;
    localparam logic [5:0] c_op_bne = 6'b011101;
    localparam logic [5:0] c_op_ldr = 6'b011111;
    localparam logic [4:0] c_r31    = 5'd31;

    // ------------------------------------------------------------------
    // Decode of the instruction held in ID
    // ------------------------------------------------------------------
    logic [5:0] w_opcode;
    logic [4:0] w_rc;
    logic [4:0] w_ra;
    logic [4:0] w_rb;
    logic [4:0] w_src2;
    logic       w_is_op;
    logic       w_is_opc;
    logic       w_is_st;
    logic       w_reads_ra;
    logic       w_reads_src2;
    logic       w_writes_rc;
    logic       w_is_load;
    logic       w_use_ra;
    logic       w_use_src2;

    assign w_opcode = id_inst[31:26];
    assign w_rc     = id_inst[25:21];
    assign w_ra     = id_inst[20:16];
    assign w_rb     = id_inst[15:11];
    assign w_src2   = id_ra2sel ? w_rc : w_rb;

    always_comb begin
        w_is_op      = (w_opcode[5:4] == 2'b10);
        w_is_opc     = (w_opcode[5:4] == 2'b11);
        w_is_st      = (w_opcode == c_op_st);
        w_is_load    = (w_opcode == c_op_ld) || (w_opcode == c_op_ldr);
        w_reads_ra   = w_is_op || w_is_opc || w_is_st
                    || (w_opcode == c_op_ld)  || (w_opcode == c_op_jmp)
                    || (w_opcode == c_op_beq) || (w_opcode == c_op_bne);
        // The second read port is Rb for ALU ops and Rc for stores.
        w_reads_src2 = w_is_op || (w_is_st && id_ra2sel);
        w_writes_rc  = w_is_op || w_is_opc || w_is_load
                    || (w_opcode == c_op_jmp)
                    || (w_opcode == c_op_beq) || (w_opcode == c_op_bne);
    end

    assign w_use_ra   = w_reads_ra   && (w_ra   != c_r31);
    assign w_use_src2 = w_reads_src2 && (w_src2 != c_r31);

    // ------------------------------------------------------------------
    // Scoreboard of destinations downstream of ID (slot 0 = EX)
    // ------------------------------------------------------------------
    logic [PIPE_DEPTH-1:0] r_sb_valid;
    logic [PIPE_DEPTH-1:0] r_sb_load;
    logic [4:0]            r_sb_rd [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] w_match;
    logic                  w_hazard;
    logic                  w_insert;

    assign w_insert = id_valid && !stall && !flush && w_writes_rc && (w_rc != c_r31);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb_valid[0] <= 1'b0;
            r_sb_load[0]  <= 1'b0;
            r_sb_rd[0]    <= 5'd0;
        end else begin
            r_sb_valid[0] <= w_insert;
            r_sb_load[0]  <= w_insert && w_is_load;
            r_sb_rd[0]    <= w_insert ? w_rc : 5'd0;
        end
    end

    generate
        for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sb_valid[k] <= 1'b0;
                    r_sb_load[k]  <= 1'b0;
                    r_sb_rd[k]    <= 5'd0;
                end else begin
                    r_sb_valid[k] <= r_sb_valid[k-1];
                    r_sb_load[k]  <= r_sb_load[k-1];
                    r_sb_rd[k]    <= r_sb_rd[k-1];
                end
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
            assign w_match[k] = r_sb_valid[k]
                             && ((w_use_ra   && (r_sb_rd[k] == w_ra))
                              || (w_use_src2 && (r_sb_rd[k] == w_src2)));
        end
    endgenerate

    generate
        if (BYPASS != 0) begin : g_bypass
            // With forwarding only a load in EX cannot supply its result in time.
            assign w_hazard = id_valid && w_match[0] && r_sb_load[0];
        end else begin : g_no_bypass
            assign w_hazard = id_valid && (|w_match);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs: flush and reset both override a hazard
    // ------------------------------------------------------------------
    assign stall  = w_hazard && !flush && !reset;
    assign bubble = (stall || flush) && !reset;

    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed self-checking bench for hazard_stall_unit, three
//            parameterisations sharing one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_inst;
    logic        id_ra2sel;
    logic        flush;

    logic        nb_stall, nb_bubble;
    logic [15:0] nb_count;
    logic        bp_stall, bp_bubble;
    logic [15:0] bp_count;
    logic        sat_stall, sat_bubble;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.PIPE_DEPTH(3), .BYPASS(0), .CNT_W(16)) u_nb (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
        .id_ra2sel(id_ra2sel), .flush(flush),
        .stall(nb_stall), .bubble(nb_bubble), .stall_count(nb_count)
    );

    hazard_stall_unit #(.PIPE_DEPTH(3), .BYPASS(1), .CNT_W(16)) u_bp (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
        .id_ra2sel(id_ra2sel), .flush(flush),
        .stall(bp_stall), .bubble(bp_bubble), .stall_count(bp_count)
    );

    hazard_stall_unit #(.PIPE_DEPTH(3), .BYPASS(0), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
        .id_ra2sel(id_ra2sel), .flush(flush),
        .stall(sat_stall), .bubble(sat_bubble), .stall_count(sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] f_add(input logic [4:0] rc, input logic [4:0] ra, input logic [4:0] rb);
        return {6'b100000, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] f_sub(input logic [4:0] rc, input logic [4:0] ra, input logic [4:0] rb);
        return {6'b100001, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] f_ld(input logic [4:0] rc, input logic [4:0] ra);
        return {6'b011000, rc, ra, 16'd0};
    endfunction

    function automatic logic [31:0] f_st(input logic [4:0] rc, input logic [4:0] ra);
        return {6'b011001, rc, ra, 16'd0};
    endfunction

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] inst, input logic valid, input logic ra2sel, input logic fl);
        id_inst   = inst;
        id_valid  = valid;
        id_ra2sel = ra2sel;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_id(f_add(5'd4, 5'd1, 5'd5), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b0 || nb_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b bubble=%b, required 0 0", nb_stall, nb_bubble);
        end
        tick();
        tick();
        checks++;
        if (nb_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d, required 0", nb_count);
        end
        reset = 1'b0;
        #1;
        // Dependent instruction after release must see an empty scoreboard.
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_slots_empty: stall=%b, required 0", nb_stall);
        end
        tick();
    endtask

    task automatic test_raw_nobypass();
        do_reset();
        set_id(f_add(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_producer: stall=%b, required 0", nb_stall);
        end
        tick();
        set_id(f_add(5'd4, 5'd1, 5'd5), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bp_stall !== 1'b0) begin
            errors++;
            $display("FAIL raw_bypass_alu: stall=%b, required 0", bp_stall);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nb_stall !== 1'b1 || nb_bubble !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall_cycle%0d: stall=%b bubble=%b, required 1 1", i, nb_stall, nb_bubble);
            end
            tick();
        end
        checks++;
        if (nb_stall !== 1'b0 || nb_bubble !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: stall=%b bubble=%b, required 0 0", nb_stall, nb_bubble);
        end
        checks++;
        if (nb_count !== 16'd3) begin
            errors++;
            $display("FAIL raw_count: got %0d, required 3", nb_count);
        end
        tick();
    endtask

    task automatic test_window_edge();
        do_reset();
        set_id(f_add(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_add(5'd10, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_add(5'd11, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        tick();
        // Producer now sits in the last tracked slot.
        set_id(f_add(5'd4, 5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b1) begin
            errors++;
            $display("FAIL window_last_slot: stall=%b, required 1", nb_stall);
        end
        tick();
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL window_after_wb: stall=%b, required 0", nb_stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(f_ld(5'd7, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_add(5'd8, 5'd7, 5'd7), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bp_stall !== 1'b1 || bp_bubble !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%b bubble=%b, required 1 1", bp_stall, bp_bubble);
        end
        tick();
        checks++;
        if (bp_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: stall=%b, required 0", bp_stall);
        end
        checks++;
        if (bp_count !== 16'd1) begin
            errors++;
            $display("FAIL load_use_count: got %0d, required 1", bp_count);
        end
        tick();

        do_reset();
        set_id(f_ld(5'd7, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_sub(5'd8, 5'd9, 5'd10), 1'b1, 1'b0, 1'b0);
        checks++;
        if (bp_stall !== 1'b0 || nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_independent: bp_stall=%b nb_stall=%b, required 0 0", bp_stall, nb_stall);
        end
        tick();
        checks++;
        if (bp_count !== 16'd0) begin
            errors++;
            $display("FAIL load_independent_count: got %0d, required 0", bp_count);
        end
    endtask

    task automatic test_r31_store();
        do_reset();
        set_id(f_add(5'd31, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_add(5'd3, 5'd31, 5'd31), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL r31_no_hazard: stall=%b, required 0", nb_stall);
        end
        tick();

        do_reset();
        set_id(f_add(5'd6, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_st(5'd6, 5'd4), 1'b1, 1'b1, 1'b0);
        checks++;
        if (nb_stall !== 1'b1) begin
            errors++;
            $display("FAIL store_rc_hazard: stall=%b, required 1", nb_stall);
        end
        set_id(f_st(5'd6, 5'd4), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL store_no_ra2sel: stall=%b, required 0", nb_stall);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        set_id(f_add(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0);
        tick();
        set_id(f_add(5'd4, 5'd1, 5'd5), 1'b1, 1'b0, 1'b1);
        checks++;
        if (nb_stall !== 1'b0 || nb_bubble !== 1'b1) begin
            errors++;
            $display("FAIL flush_priority: stall=%b bubble=%b, required 0 1", nb_stall, nb_bubble);
        end
        tick();
        set_id(f_add(5'd9, 5'd4, 5'd4), 1'b1, 1'b0, 1'b0);
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_not_entered: stall=%b, required 0", nb_stall);
        end
        tick();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        // Self-dependent op held in ID: 1 free cycle then 3 stalls, repeating.
        set_id(f_add(5'd1, 5'd1, 5'd1), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (sat_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_count: got %0d, required 15", sat_count);
        end
        checks++;
        if (nb_count !== 16'd30) begin
            errors++;
            $display("FAIL wide_count: got %0d, required 30", nb_count);
        end
        tick();
        checks++;
        if (nb_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_setup: stall=%b, required 1", nb_stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (nb_stall !== 1'b0 || nb_bubble !== 1'b0 || sat_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_stall: stall=%b bubble=%b sat_stall=%b, required 0 0 0",
                     nb_stall, nb_bubble, sat_stall);
        end
        tick();
        checks++;
        if (nb_count !== 16'd0 || sat_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_count: nb=%0d sat=%0d, required 0 0", nb_count, sat_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (nb_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_stale_entries: stall=%b, required 0", nb_stall);
        end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        id_valid  = 1'b0;
        id_inst   = 32'd0;
        id_ra2sel = 1'b0;
        flush     = 1'b0;
        #2;
        test_reset();
        test_raw_nobypass();
        test_window_edge();
        test_load_use();
        test_r31_store();
        test_flush();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Generates the `stall` input of the IF/ID pipeline register for the pipelined Beta core. It is the producer end of the stall/bubble interface.
- Keeps an internal scoreboard of destination registers that are in flight downstream of ID (EX, MEM, WB).
- Compares that scoreboard with the source registers of the instruction currently held in ID.
- On a RAW hazard it holds IF/ID and tells ID/EX to take a bubble. It also counts stall cycles for performance debug.

Parameters:
- PIPE_DEPTH, 3, number of in-flight stages tracked after ID (slot 0 = EX … slot PIPE_DEPTH-1 = WB); legal range 1..4.
- BYPASS, 0, 0 = no forwarding, so a hazard is any match in any valid slot; 1 = full forwarding, so a hazard is only a load in slot 0 (load-use).
- CNT_W, 16, width of the stall cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction (0 = bubble).
- id_inst  input  32  instruction in ID (the `ID_ID` bus): opcode [31:26], Rc [25:21], Ra [20:16], Rb [15:11].
- id_ra2sel  input  1  second read port uses Rc instead of Rb (ST).
- flush  input  1  taken branch/jump: kill the instruction in ID this cycle.
- stall  output  1  hold IF/ID and PC.
- bubble  output  1  load a NOP into ID/EX this cycle.
- stall_count  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Decode (combinational, from id_inst):
  - OP (10xxxx): reads Ra, Rb; writes Rc.
  - OPC (11xxxx): reads Ra; writes Rc.
  - LD (011000): reads Ra; writes Rc; is a load.
  - ST (011001): reads Ra and, via id_ra2sel, Rc; writes nothing.
  - JMP (011011), BEQ (011100), BNE (011101): read Ra; write Rc.
  - LDR (011111): reads nothing; writes Rc; is a load.
  - Any other opcode: reads and writes nothing.
- Register 31 is never a hazard, as source or destination. A destination of R31 is not entered into the scoreboard.
- Scoreboard:
  - PIPE_DEPTH entries, each {valid, rd[4:0], is_load}.
  - Every clock the contents shift: slot k moves to slot k+1, and slot PIPE_DEPTH-1 is discarded.
  - Slot 0 loads the ID instruction's entry only when id_valid=1, stall=0, flush=0, and the instruction writes a register other than R31. Otherwise slot 0 loads valid=0 (a bubble).
- Hazard:
  - BYPASS=0: hazard = id_valid & any valid slot whose rd equals a used source register.
  - BYPASS=1: hazard = id_valid & slot0.valid & slot0.is_load & slot0.rd equals a used source register.
- Outputs:
  - stall = hazard & ~flush & ~reset. This is combinational, so IF/ID sees it in the same cycle.
  - bubble = stall | flush.
  - flush has priority over hazard: when both are high, stall=0 and bubble=1.
- Latency:
  - A hazard resolves once the producer leaves the matching window. With BYPASS=0 and a back-to-back dependency, stall is high for exactly PIPE_DEPTH cycles.
  - With BYPASS=1 and a back-to-back load-use, stall is high for exactly 1 cycle.
- stall_count:
  - Registered; increments by 1 on each cycle with stall=1.
  - Saturates at all-ones and does not wrap.
- Reset:
  - While reset=1: every scoreboard entry is cleared to valid=0, stall_count=0, and stall=0, bubble=0 are forced.
  - A reset asserted in the middle of a stall ends the stall on that same cycle. No stale entries survive reset.
- Simultaneous events:
  - Shift and insert happen on the same edge. An instruction is never compared against its own entry.
  - Ra==Rb both matching counts as one hazard.

Test Plan:
- Reset: hold reset 2 cycles with a dependent instruction in ID -> stall=0, bubble=0, stall_count=0; all slots invalid after release.
- No-bypass RAW (BYPASS=0, PIPE_DEPTH=3): ADD R1,R2,R3 then ADD R4,R1,R5, both id_valid -> stall=1 for exactly 3 cycles, bubble=1 for those 3 cycles, stall_count=3, second ADD then proceeds.
- Load-use (BYPASS=1): LD R7,0(R2) then ADD R8,R7,R7 -> stall=1 for exactly 1 cycle, stall_count=1. Same sequence with ADD replaced by SUB R8,R9,R10 -> stall never asserted.
- R31 and ST: ADD R31,R1,R2 then ADD R3,R31,R31 -> no stall. ADD R6,R1,R2 then ST R6,0(R4) with id_ra2sel=1 -> stall asserted (BYPASS=0).
- Flush priority: flush=1 in the first cycle of a hazard -> stall=0, bubble=1; the flushed instruction's Rc is never entered into slot 0, and the next instruction reading it does not stall.
- Saturation/reset mid-stall: CNT_W=4, force 20 stall cycles -> stall_count holds at 15. Assert reset during a stall -> stall drops the same cycle and stall_count=0 next cycle.
